instr_trace_uart_tx: RTL

INSTR_TRACE_UART_TX -- requirements
Module: instr_trace_uart_tx

---
 rtl/instr_trace_uart_tx_pkg.sv | 16 +
 rtl/instr_trace_uart_tx_if.sv | 23 ++
 rtl/instr_trace_uart_tx_fifo.sv | 51 +++++
 rtl/instr_trace_uart_tx.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/instr_trace_uart_tx_pkg.sv
// Shared types and constants for the instruction trace UART.
// Imported by the FIFO bus interface and the trace transmitter.
package instr_trace_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 434;
    localparam logic [31:0] DEF_HALT_WORD = 32'h0000_0001;
    localparam int unsigned TRACE_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

endpackage

// File: rtl/instr_trace_uart_tx_if.sv
// Push/pop bus between the trace capture logic and its FIFO.
// master drives push/pop/data, slave reports data and status.
interface trace_fifo_if;
    import instr_trace_pkg::*;

    logic               push;
    logic               pop;
    logic [TRACE_W-1:0] wdata;
    logic [TRACE_W-1:0] rdata;
    logic               full;
    logic               empty;

    modport master (
        output push, pop, wdata,
        input  rdata, full, empty
    );

    modport slave (
        input  push, pop, wdata,
        output rdata, full, empty
    );

endinterface

// File: rtl/instr_trace_uart_tx_fifo.sv
// Single-clock show-ahead FIFO with count-based full/empty.
// A push while full is accepted only when a pop frees a slot.
module trace_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input logic        clk,
    input logic        rst,
    trace_fifo_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign bus.full  = (count == CW'(DEPTH));
    assign bus.empty = (count == '0);
    assign bus.rdata = mem[rd_ptr];

    assign do_pop  = bus.pop && !bus.empty;
    assign do_push = bus.push && (!bus.full || do_pop);

    // Storage array; contents need no reset, pointers guard them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_trace_uart_tx.sv
// Captures retiring instructions into a FIFO and streams each
// word as four 8N1 UART frames, most significant byte first.
module instr_trace_uart_tx
    import instr_trace_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [31:0] HALT_WORD    = DEF_HALT_WORD
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] instr_wb,
    input  logic        instr_wb_valid,
    output logic        uart_TXD,
    output logic        fifo_overflow,
    output logic        halt_seen,
    output logic        busy
);
    localparam int unsigned BW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    trace_fifo_if fifo_bus ();

    trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk (clk_clk),
        .rst (reset_reset),
        .bus (fifo_bus.slave)
    );

    tx_state_e     state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   sreg;
    logic [7:0]    cur_byte;
    logic          baud_last;
    logic          want;
    logic          pop;
    logic          push;
    logic          line;

    assign baud_last = (baud == BAUD_LAST);
    assign cur_byte  = sreg[31:24];

    // Words are taken only in IDLE; a full FIFO still accepts
    // a word on the edge where IDLE frees a slot.
    assign pop  = (state == S_IDLE) && !fifo_bus.empty;
    assign want = instr_wb_valid && !halt_seen;
    assign push = want && (!fifo_bus.full || pop);

    assign fifo_bus.push  = push;
    assign fifo_bus.pop   = pop;
    assign fifo_bus.wdata = instr_wb;

    // Line level implied by the current state, registered below.
    always_comb begin
        line = 1'b1;
        unique case (state)
            S_START: line = 1'b0;
            S_DATA:  line = cur_byte[bit_idx];
            default: line = 1'b1;
        endcase
    end

    // Sticky capture flags: halt on accepted sentinel, overflow on drop.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            halt_seen     <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            if (push && (instr_wb == HALT_WORD)) halt_seen <= 1'b1;
            if (want && !push) fifo_overflow <= 1'b1;
        end
    end

    // Serializer FSM with registered line and busy outputs.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state    <= S_IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            sreg     <= '0;
            uart_TXD <= 1'b1;
            busy     <= 1'b0;
        end else begin
            uart_TXD <= line;
            busy     <= (state != S_IDLE) || !fifo_bus.empty;
            unique case (state)
                S_IDLE: begin
                    if (!fifo_bus.empty) begin
                        sreg     <= fifo_bus.rdata;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        baud     <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud  <= '0;
                        state <= S_DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 1'b1;
                            sreg     <= {sreg[23:0], 8'h00};
                            state    <= S_START;
                        end else begin
                            byte_idx <= '0;
                            state    <= S_IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
